mem_access_unit: RTL and testbench

- Memory-stage data access controller. Sits between the EX/MEM pipeline register and the MEM/WB register.
- Converts a load or store issued in MEM into a req/ack data-bus transaction.
- Holds the pipeline (StallM) until the transaction completes, then presents the raw loaded word as RamDataM.
- Byte-lane selection and load sign/zero extension are done downstream from LoadedBytesSelect; this block returns whole aligned words.

---
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 tb/tb_mem_access_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : MEM-stage load/store to req/ack data-bus bridge with pipeline stall.
//            Optional macro MEM_TIMEOUT_EN adds a bus_ack timeout with bus_err.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int unsigned  TIMEOUT  = 255,
    parameter logic [31:0]  ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] AluOutM,
    input  logic [31:0] StoreDataM,
    input  logic [3:0]  MemWriteM,
    input  logic        MemReadM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] RamDataM,
    output logic        StallM,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        we_q,    we_d;
    logic [31:0] rdata_q, rdata_d;
    logic        w_access;
    logic        w_timeout;

    assign w_access = MemReadM | (MemWriteM != 4'b0000);

`ifdef MEM_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    // An ack in the timeout cycle completes normally, so it masks the timeout.
    assign w_timeout = (state_q == REQ) && !bus_ack && (cnt_q == c_TIMEOUT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q != REQ) begin
            cnt_d = 8'd0;
        end else if (!bus_ack) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus_err = w_timeout;
`else
    logic [7:0] w_unused_timeout;

    assign w_unused_timeout = c_TIMEOUT_LAST;
    assign w_timeout        = 1'b0;
    assign bus_err          = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (w_access) begin
                    // Lanes beyond byte 3 are simply dropped: no misalignment trap.
                    addr_d  = {AluOutM[31:2], 2'b00};
                    wstrb_d = MemWriteM << AluOutM[1:0];
                    wdata_d = StoreDataM << {AluOutM[1:0], 3'b000};
                    we_d    = (MemWriteM != 4'b0000);
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus_ack) begin
                    if (!we_q) begin
                        rdata_d = bus_rdata;
                    end
                    state_d = DONE;
                end else if (w_timeout) begin
                    if (!we_q) begin
                        rdata_d = ERR_DATA;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            we_q    <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    // DONE is the single cycle in which the pipeline is allowed to advance.
    assign StallM    = w_access & (state_q != DONE);
    assign bus_req   = (state_q == REQ);
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_wstrb = wstrb_q;
    assign RamDataM  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Directed scoreboard bench for mem_access_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] AluOutM;
    logic [31:0] StoreDataM;
    logic [3:0]  MemWriteM;
    logic        MemReadM;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic [31:0] RamDataM;
    logic        StallM;
    logic        bus_err;

    mem_access_unit #(
        .TIMEOUT  (4),
        .ERR_DATA (32'hDEADBEEF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .AluOutM    (AluOutM),
        .StoreDataM (StoreDataM),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wstrb  (bus_wstrb),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .RamDataM   (RamDataM),
        .StallM     (StallM),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        logic [31:0] ram;
        int          stalls;
        int          errs;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_reset(input int cycles);
        @(posedge clk); #1;
        rst = 1'b1; MemReadM = 1'b0; MemWriteM = 4'b0; bus_ack = 1'b0;
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic idle(input int cycles);
        @(posedge clk); #1;
        MemReadM = 1'b0; MemWriteM = 4'b0; AluOutM = 32'd0; StoreDataM = 32'd0; bus_ack = 1'b0;
        repeat (cycles - 1) @(posedge clk);
    endtask

    // Issues one instruction in MEM and plays the bus slave; returns in the DONE cycle.
    task automatic do_access(
        input logic [31:0] addr, input logic [31:0] sdata, input logic [3:0] mask,
        input logic rd, input int ack_after, input logic [31:0] rdata,
        input logic [31:0] e_addr, input logic e_we, input logic [31:0] e_wdata,
        input logic [3:0] e_wstrb, input logic [31:0] e_ram, input int e_stalls, input int e_errs);
        req_t r;
        rsp_t s;
        int   reqcyc;
        int   n;
        r.addr = e_addr; r.we = e_we; r.wdata = e_wdata; r.wstrb = e_wstrb;
        s.ram = e_ram; s.stalls = e_stalls; s.errs = e_errs;
        @(posedge clk); #1;
        req_q.push_back(r);
        rsp_q.push_back(s);
        AluOutM = addr; StoreDataM = sdata; MemWriteM = mask; MemReadM = rd;
        reqcyc = 0;
        n = 0;
        while (1) begin
            @(posedge clk); #1;
            n++;
            if (!StallM) begin
                bus_ack = 1'b0;
                break;
            end
            if (n > 60) begin
                checks++; errors++;
                $display("FAIL access_timeout: got stall after %0d cycles expected completion", n);
                apply_reset(2);
                break;
            end
            if (bus_req) begin
                reqcyc++;
                bus_ack   = (reqcyc == ack_after);
                bus_rdata = rdata;
            end else begin
                bus_ack = 1'b0;
            end
        end
    endtask

    // Monitor: checks bus request fields every REQ cycle and the response on completion.
    req_t cur;
    rsp_t got;
    int   stall_cnt = 0;
    int   err_cnt   = 0;
    logic prev_req  = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            req_q.delete(); rsp_q.delete();
            stall_cnt = 0; err_cnt = 0; prev_req = 1'b0;
        end else begin
            if (bus_err) err_cnt++;
            if (bus_req && !prev_req) begin
                if (req_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req: got bus_req=1 expected no request");
                end else begin
                    cur = req_q.pop_front();
                end
            end
            if (bus_req) begin
                chk("bus_addr",  bus_addr,  cur.addr);
                chk("bus_we",    {31'd0, bus_we}, {31'd0, cur.we});
                chk("bus_wdata", bus_wdata, cur.wdata);
                chk("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, cur.wstrb});
            end
            prev_req = bus_req;
            if (MemReadM || (MemWriteM != 4'b0)) begin
                if (StallM) begin
                    stall_cnt++;
                end else begin
                    if (rsp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done: got completion expected none");
                    end else begin
                        got = rsp_q.pop_front();
                        chk("RamDataM",    RamDataM, got.ram);
                        chk("stall_cycles", 32'(stall_cnt), 32'(got.stalls));
                        chk("bus_err_cnt",  32'(err_cnt),   32'(got.errs));
                        chk("req_in_done",  {31'd0, bus_req}, 32'd0);
                    end
                    stall_cnt = 0;
                    err_cnt   = 0;
                end
            end
        end
    end

    initial begin
        rst = 1'b1; AluOutM = 32'd0; StoreDataM = 32'd0; MemWriteM = 4'b0;
        MemReadM = 1'b0; bus_ack = 1'b0; bus_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bus_req",   {31'd0, bus_req}, 32'd0);
        chk("rst_bus_we",    {31'd0, bus_we},  32'd0);
        chk("rst_bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
        chk("rst_bus_addr",  bus_addr,  32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_RamDataM",  RamDataM,  32'd0);
        chk("rst_bus_err",   {31'd0, bus_err}, 32'd0);
        chk("rst_StallM",    {31'd0, StallM},  32'd0);
        rst = 1'b0;
        idle(2);

        // Byte store at offset 2, ack in the second REQ cycle
        do_access(32'h1002, 32'h000000AB, 4'b0001, 1'b0, 2, 32'h0,
                  32'h1000, 1'b1, 32'h00AB0000, 4'b0100, 32'h0, 3, 0);
        idle(2);
        // Word load, ack in the first REQ cycle, then a store that must not disturb RamDataM
        do_access(32'h2000, 32'h0, 4'b0000, 1'b1, 1, 32'h12345678,
                  32'h2000, 1'b0, 32'h0, 4'b0000, 32'h12345678, 2, 0);
        do_access(32'h3003, 32'h0000BEEF, 4'b0011, 1'b0, 1, 32'hFFFF0000,
                  32'h3000, 1'b1, 32'hEF000000, 4'b1000, 32'h12345678, 2, 0);
        idle(1);
        // Back-to-back load then store
        do_access(32'h4004, 32'h0, 4'b0000, 1'b1, 1, 32'hCAFEF00D,
                  32'h4004, 1'b0, 32'h0, 4'b0000, 32'hCAFEF00D, 2, 0);
        do_access(32'h4008, 32'h11223344, 4'b1111, 1'b0, 1, 32'h55555555,
                  32'h4008, 1'b1, 32'h11223344, 4'b1111, 32'hCAFEF00D, 2, 0);
        // Load and store together: store wins
        do_access(32'h5001, 32'hA1B2C3D4, 4'b1111, 1'b1, 3, 32'h77777777,
                  32'h5000, 1'b1, 32'hB2C3D400, 4'b1110, 32'hCAFEF00D, 4, 0);
        // Load at offset 3 still latches shifted store data with no strobes
        do_access(32'h6003, 32'h00000055, 4'b0000, 1'b1, 2, 32'h89ABCDEF,
                  32'h6000, 1'b0, 32'h55000000, 4'b0000, 32'h89ABCDEF, 3, 0);

        // Stray ack while idle
        idle(1);
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        chk("stray_ack_ram", RamDataM, 32'h89ABCDEF);
        chk("stray_ack_req", {31'd0, bus_req}, 32'd0);

        // Reset in the middle of REQ, then a late ack
        @(posedge clk); #1;
        AluOutM = 32'h7100; MemReadM = 1'b1;
        @(posedge clk); #1;
        chk("req_before_rst", {31'd0, bus_req}, 32'd1);
        rst = 1'b1; MemReadM = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h99999999;
        chk("post_rst_req",   {31'd0, bus_req}, 32'd0);
        chk("post_rst_ram",   RamDataM, 32'd0);
        chk("post_rst_stall", {31'd0, StallM}, 32'd0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        chk("late_ack_req", {31'd0, bus_req}, 32'd0);
        chk("late_ack_ram", RamDataM, 32'd0);
        do_access(32'h7000, 32'h0, 4'b0000, 1'b1, 1, 32'h0BADF00D,
                  32'h7000, 1'b0, 32'h0, 4'b0000, 32'h0BADF00D, 2, 0);

`ifdef MEM_TIMEOUT_EN
        idle(1);
        // No ack: timeout on the 4th REQ cycle
        do_access(32'h8000, 32'h0, 4'b0000, 1'b1, 0, 32'h0,
                  32'h8000, 1'b0, 32'h0, 4'b0000, 32'hDEADBEEF, 5, 1);
        idle(1);
        // Ack on the timeout cycle completes normally
        do_access(32'h8004, 32'h0, 4'b0000, 1'b1, 4, 32'h600DCAFE,
                  32'h8004, 1'b0, 32'h0, 4'b0000, 32'h600DCAFE, 5, 0);
`endif
        idle(3);
        chk("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
        chk("req_queue_empty", 32'(req_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
